// File: rtl/seq_divider32.sv
// -----------------------------------------------------------------------------
// seq_divider32
//   Iterative restoring divider. Computes QUOT = A / B and REM = A % B for
//   signed (two's-complement) or unsigned operands under a start/done
//   handshake. Only one division is in flight at a time.
//
//   The quotient truncates toward zero and the remainder takes the sign of
//   the dividend. A zero divisor takes a short path that reports
//   div_by_zero, an all-ones quotient and the raw dividend as the remainder.
//
//   Optional build macro:
//     DIV_RADIX4_EN  retire two quotient bits per CALC edge (two cascaded
//                    trial subtracts); latency WIDTH/2+1 instead of WIDTH+1.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset (aborts any operation)
//   start        request, sampled only while busy=0
//   A, B         dividend / divisor, sampled with start
//   alu_signed   1 = two's-complement operands, 0 = unsigned
//   busy         division in progress
//   done         one-cycle pulse, results valid from this cycle
//   div_by_zero  B was zero; valid with done, held
//   QUOT, REM    quotient / remainder, held until the next done
// -----------------------------------------------------------------------------
module seq_divider32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             alu_signed,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] QUOT,
    output logic [WIDTH-1:0] REM
);

    localparam int CW = $clog2(WIDTH);
`ifdef DIV_RADIX4_EN
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH/2 - 1);
`else
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DBZ  = 2'd3
    } state_t;

    // One restoring step: shift {rem,quot} left, trial-subtract the divisor
    // with one extra bit so the borrow is visible, keep the difference if it
    // did not go negative. Returns {rem_next, quot_next}.
    function automatic logic [2*WIDTH-1:0] div_step(
        input logic [WIDTH-1:0] rem_in,
        input logic [WIDTH-1:0] quot_in,
        input logic [WIDTH-1:0] dvs
    );
        logic [WIDTH:0] shifted;
        logic [WIDTH:0] diff;
        shifted = {rem_in, quot_in[WIDTH-1]};
        diff    = shifted - {1'b0, dvs};
        if (diff[WIDTH]) begin
            // Negative: shifted < dvs, so it still fits in WIDTH bits.
            div_step = {shifted[WIDTH-1:0], quot_in[WIDTH-2:0], 1'b0};
        end else begin
            div_step = {diff[WIDTH-1:0], quot_in[WIDTH-2:0], 1'b1};
        end
    endfunction

    state_t           state_r, state_s;
    logic [WIDTH-1:0] rem_r, rem_s;       // partial remainder
    logic [WIDTH-1:0] quot_r, quot_s;     // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] dvs_r, dvs_s;       // divisor magnitude
    logic [CW-1:0]    cnt_r, cnt_s;
    logic             qsign_r, qsign_s;
    logic             rsign_r, rsign_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             dbz_r, dbz_s;
    logic [WIDTH-1:0] quot_out_r, quot_out_s;
    logic [WIDTH-1:0] rem_out_r, rem_out_s;
    logic [2*WIDTH-1:0] step1_s;
    logic [2*WIDTH-1:0] step_s;
`ifdef DIV_RADIX4_EN
    logic [2*WIDTH-1:0] step2_s;
`endif

    // Datapath step for the current CALC edge (one or two quotient bits).
    always_comb begin
        step1_s = div_step(rem_r, quot_r, dvs_r);
`ifdef DIV_RADIX4_EN
        step2_s = div_step(step1_s[2*WIDTH-1:WIDTH], step1_s[WIDTH-1:0], dvs_r);
        step_s  = step2_s;
`else
        step_s  = step1_s;
`endif
    end

    // Next-state and next-output logic.
    always_comb begin
        state_s    = state_r;
        rem_s      = rem_r;
        quot_s     = quot_r;
        dvs_s      = dvs_r;
        cnt_s      = cnt_r;
        qsign_s    = qsign_r;
        rsign_s    = rsign_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        dbz_s      = dbz_r;
        quot_out_s = quot_out_r;
        rem_out_s  = rem_out_r;

        case (state_r)
            IDLE: begin
                if (start) begin
                    busy_s = 1'b1;
                    if (B == {WIDTH{1'b0}}) begin
                        // Keep the raw dividend; it becomes REM.
                        state_s = DBZ;
                        quot_s  = A;
                    end else begin
                        state_s = CALC;
                        quot_s  = (alu_signed && A[WIDTH-1]) ? ({WIDTH{1'b0}} - A) : A;
                        dvs_s   = (alu_signed && B[WIDTH-1]) ? ({WIDTH{1'b0}} - B) : B;
                        qsign_s = alu_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                        rsign_s = alu_signed & A[WIDTH-1];
                        rem_s   = {WIDTH{1'b0}};
                        cnt_s   = CNT_INIT;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                rem_s  = step_s[2*WIDTH-1:WIDTH];
                quot_s = step_s[WIDTH-1:0];
                cnt_s  = cnt_r - 1'b1;
                if (cnt_r == {CW{1'b0}}) begin
                    state_s = FIX;
                end else begin
                    state_s = CALC;
                end
            end
            FIX: begin
                // The -2^(W-1)/-1 case lands here with magnitude 2^(W-1)
                // and a positive sign, which wraps to the expected value.
                quot_out_s = qsign_r ? ({WIDTH{1'b0}} - quot_r) : quot_r;
                rem_out_s  = rsign_r ? ({WIDTH{1'b0}} - rem_r) : rem_r;
                done_s     = 1'b1;
                busy_s     = 1'b0;
                dbz_s      = 1'b0;
                state_s    = IDLE;
            end
            DBZ: begin
                quot_out_s = {WIDTH{1'b1}};
                rem_out_s  = quot_r;
                done_s     = 1'b1;
                busy_s     = 1'b0;
                dbz_s      = 1'b1;
                state_s    = IDLE;
            end
            default: begin
                busy_s  = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            rem_r      <= {WIDTH{1'b0}};
            quot_r     <= {WIDTH{1'b0}};
            dvs_r      <= {WIDTH{1'b0}};
            cnt_r      <= {CW{1'b0}};
            qsign_r    <= 1'b0;
            rsign_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            dbz_r      <= 1'b0;
            quot_out_r <= {WIDTH{1'b0}};
            rem_out_r  <= {WIDTH{1'b0}};
        end else begin
            state_r    <= state_s;
            rem_r      <= rem_s;
            quot_r     <= quot_s;
            dvs_r      <= dvs_s;
            cnt_r      <= cnt_s;
            qsign_r    <= qsign_s;
            rsign_r    <= rsign_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            dbz_r      <= dbz_s;
            quot_out_r <= quot_out_s;
            rem_out_r  <= rem_out_s;
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign div_by_zero = dbz_r;
    assign QUOT        = quot_out_r;
    assign REM         = rem_out_r;

endmodule

// File: tb/tb_seq_divider32.sv
// Scoreboard bench for seq_divider32: stimulus pushes expected results
// (including the cycle at which done must appear) and a monitor pops and
// compares on every done pulse.
module tb_seq_divider32;

`ifdef DIV_RADIX4_EN
    localparam int LAT = 17;
`else
    localparam int LAT = 33;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic        alu_signed;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] QUOT;
    logic [31:0] REM;

    seq_divider32 #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .A           (A),
        .B           (B),
        .alu_signed  (alu_signed),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .QUOT        (QUOT),
        .REM         (REM)
    );

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        logic [31:0] due;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] cyc = 32'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 32'd1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected entry.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got QUOT=%h REM=%h with no pending op", QUOT, REM);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("quot", QUOT, mon_e.q);
                    check("rem", REM, mon_e.r);
                    check("div_by_zero", {31'd0, div_by_zero}, {31'd0, mon_e.dbz});
                    check("latency_cycle", cyc, mon_e.due);
                end
            end
        end
    end

    // Issue one accepted op from a negedge; returns at the negedge after E0.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [31:0] eq, input logic [31:0] er, input logic ed);
        exp_t e;
        A = a;
        B = b;
        alu_signed = s;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        A = 32'hDEADBEEF;
        B = 32'h0BADF00D;
        alu_signed = ~s;
        @(negedge clk);
        e.q = eq;
        e.r = er;
        e.dbz = ed;
        e.due = cyc + (ed ? 32'd1 : 32'(LAT));
        exp_q.push_back(e);
        check("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done();
        logic found;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done within 200 cycles, required one");
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [31:0] eq, input logic [31:0] er, input logic ed);
        issue(a, b, s, eq, er, ed);
        wait_done();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        A = 32'd0;
        B = 32'd0;
        alu_signed = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_dbz", {31'd0, div_by_zero}, 32'd0);
        check("reset_quot", QUOT, 32'd0);
        check("reset_rem", REM, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed vectors; consecutive run_op calls start in the done cycle.
        run_op(32'd100,        32'd7,        1'b0, 32'd14,        32'd2,        1'b0);
        run_op(32'hFFFFFF9C,   32'd7,        1'b1, 32'hFFFFFFF2,  32'hFFFFFFFE, 1'b0);
        run_op(32'd100,        32'hFFFFFFF9, 1'b1, 32'hFFFFFFF2,  32'd2,        1'b0);
        @(negedge clk);
        run_op(32'h12345678,   32'd0,        1'b0, 32'hFFFFFFFF,  32'h12345678, 1'b1);
        run_op(32'h80000000,   32'hFFFFFFFF, 1'b1, 32'h80000000,  32'd0,        1'b0);
        run_op(32'h80000000,   32'hFFFFFFFF, 1'b0, 32'd0,         32'h80000000, 1'b0);
        repeat (3) @(negedge clk);
        run_op(32'hFFFFFFEB,   32'd7,        1'b1, 32'hFFFFFFFD,  32'd0,        1'b0);
        run_op(32'd7,          32'd100,      1'b0, 32'd0,         32'd7,        1'b0);
        run_op(32'hFFFFFFFB,   32'd0,        1'b1, 32'hFFFFFFFF,  32'hFFFFFFFB, 1'b1);
        run_op(32'hFFFFFFF9,   32'hFFFFFFFE, 1'b1, 32'd3,         32'hFFFFFFFF, 1'b0);
        run_op(32'hFFFFFFFF,   32'd1,        1'b0, 32'hFFFFFFFF,  32'd0,        1'b0);
        run_op(32'h7FFFFFFF,   32'd2,        1'b1, 32'h3FFFFFFF,  32'd1,        1'b0);
        run_op(32'hFFFFFFFF,   32'hFFFFFFFF, 1'b0, 32'd1,         32'd0,        1'b0);
        run_op(32'hFFFFFF9C,   32'd7,        1'b0, 32'h24924916,  32'd2,        1'b0);
        @(negedge clk);

        // start re-pulsed around E10 while busy must be ignored.
        issue(32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, 1'b0);
        repeat (9) @(negedge clk);
        A = 32'd5;
        B = 32'd1;
        alu_signed = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_mid_op", {31'd0, busy}, 32'd1);
        wait_done();
        repeat (2) @(negedge clk);

        // Reset mid-operation: outputs clear at once, no done follows.
        issue(32'd500, 32'd9, 1'b0, 32'd55, 32'd5, 1'b0);
        repeat (14) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_dbz", {31'd0, div_by_zero}, 32'd0);
        check("abort_quot", QUOT, 32'd0);
        check("abort_rem", REM, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT + 5) @(negedge clk);

        // Fresh op after the abort.
        run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
        repeat (3) @(negedge clk);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_ops: got %0d outstanding expected results, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
